// File: rtl/pipe_stage_reg.sv
// DEPTH-stage valid/ready register chain with bubble collapse, synchronous flush,
// an optional skid entry that registers in_ready, and an occupancy counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  input  logic                              flush,
  output logic [$clog2(DEPTH+SKID+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + SKID + 1);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            src_v;
  logic [DEPTH-1:0][WIDTH-1:0] src_d;
  logic                        in_fire, out_fire;
  logic [CW-1:0]               count_q, count_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = v_q[DEPTH-1] & out_ready;

  // Stage k can take a new entry unless it and every stage after it are full and stalled.
  // Written in closed form so no ready bit depends on another ready bit.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rdy
      assign rdy[gi] = out_ready | ~(&v_q[DEPTH-1:gi]);
    end
    for (gi = 1; gi < DEPTH; gi++) begin : g_src
      assign src_v[gi] = v_q[gi-1];
      assign src_d[gi] = d_q[gi-1];
    end
  endgenerate

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_v_q, skid_v_d;
      logic [WIDTH-1:0] skid_d_q, skid_d_d;

      assign in_ready = ~skid_v_q;
      assign src_v[0] = skid_v_q | in_fire;
      assign src_d[0] = skid_v_q ? skid_d_q : in_data;

      // A held skid entry always wins S0; a new input parks here whenever S0 is blocked
      // or is being filled from the skid entry in the same cycle.
      always_comb begin
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (flush) begin
          skid_v_d = 1'b0;
        end else begin
          if (skid_v_q && rdy[0]) begin
            skid_v_d = 1'b0;
          end
          if (in_fire && (skid_v_q || !rdy[0])) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skid_v_q <= 1'b0;
          skid_d_q <= RESET_VAL;
        end else begin
          skid_v_q <= skid_v_d;
          skid_d_q <= skid_d_d;
        end
      end
    end else begin : g_noskid
      assign in_ready = rdy[0] & ~flush;
      assign src_v[0] = in_fire;
      assign src_d[0] = in_data;
    end
  endgenerate

  // Data only moves when a valid payload arrives; flush clears valids but keeps data.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        v_d[k] = 1'b0;
      end else if (rdy[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          d_d[k] = src_d[k];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      d_q     <= {DEPTH{RESET_VAL}};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: four configurations of pipe_stage_reg share one clock and reset,
// each exercised by a linear sequence of steps with hand-computed expectations.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  // A: DEPTH=3 SKID=1 RESET_VAL=DEADBEEF
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;
  // B: DEPTH=2 SKID=1
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;
  // C: DEPTH=4 SKID=1
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [31:0] c_in_data, c_out_data;
  logic [2:0]  c_count;
  // D: DEPTH=2 SKID=0
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_flush;
  logic [31:0] d_in_data, d_out_data;
  logic [1:0]  d_count;

  pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .SKID(1), .RESET_VAL(32'hDEAD_BEEF)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .flush(a_flush), .count(a_count));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .SKID(1), .RESET_VAL(32'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .flush(b_flush), .count(b_count));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(4), .SKID(1), .RESET_VAL(32'h0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .flush(c_flush), .count(c_count));

  pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .SKID(0), .RESET_VAL(32'h0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .flush(d_flush), .count(d_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streaming expectations on A after edges 1..7 (inputs 1..4 on edges 1..4)
  logic [31:0] s_ov  [7] = '{0, 0, 1, 1, 1, 1, 0};
  logic [31:0] s_od  [7] = '{0, 0, 1, 2, 3, 4, 0};
  logic [31:0] s_cnt [7] = '{1, 2, 3, 3, 2, 1, 0};

  initial begin
    rst_n = 1'b1;
    {a_in_valid, a_out_ready, a_flush} = '0; a_in_data = '0;
    {b_in_valid, b_out_ready, b_flush} = '0; b_in_data = '0;
    {c_in_valid, c_out_ready, c_flush} = '0; c_in_data = '0;
    {d_in_valid, d_out_ready, d_flush} = '0; d_in_data = '0;
    #1 rst_n = 1'b0;
    #11;

    // Reset state
    chk("rst_a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_a_out_data", a_out_data, 32'hDEAD_BEEF);
    chk("rst_a_count", {29'd0, a_count}, 32'd0);
    chk("rst_a_in_ready", {31'd0, a_in_ready}, 32'd1);
    rst_n = 1'b1;
    $display("reset: out_valid=%0b out_data=%0h count=%0d in_ready=%0b",
             a_out_valid, a_out_data, a_count, a_in_ready);

    // Streaming through A with out_ready=1
    a_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i < 4);
      a_in_data  = 32'(i + 1);
      tick();
      chk($sformatf("stream_ov_e%0d", i + 1), {31'd0, a_out_valid}, s_ov[i]);
      if (s_ov[i] == 32'd1) chk($sformatf("stream_od_e%0d", i + 1), a_out_data, s_od[i]);
      chk($sformatf("stream_cnt_e%0d", i + 1), {29'd0, a_count}, s_cnt[i]);
      chk($sformatf("stream_inrdy_e%0d", i + 1), {31'd0, a_in_ready}, 32'd1);
      $display("stream edge %0d: out_valid=%0b out_data=%0h count=%0d",
               i + 1, a_out_valid, a_out_data, a_count);
    end
    a_in_valid = 1'b0;

    // Backpressure on B: three pushes fill both stages and the skid entry
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 32'(10 + i);
      tick();
      chk($sformatf("bp_cnt_push%0d", i), {30'd0, b_count}, 32'(i + 1));
      $display("backpressure push %0d: count=%0d in_ready=%0b", 10 + i, b_count, b_in_ready);
    end
    chk("bp_in_ready_full", {31'd0, b_in_ready}, 32'd0);
    b_in_data = 32'd13;
    tick();
    chk("bp_cnt_after_rejected", {30'd0, b_count}, 32'd3);
    chk("bp_out_data_held", b_out_data, 32'd10);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp_drain_ov%0d", j), {31'd0, b_out_valid}, 32'd1);
      chk($sformatf("bp_drain_od%0d", j), b_out_data, 32'(10 + j));
      $display("backpressure drain: out_data=%0d count=%0d", b_out_data, b_count);
      tick();
    end
    chk("bp_empty_ov", {31'd0, b_out_valid}, 32'd0);
    chk("bp_empty_cnt", {30'd0, b_count}, 32'd0);

    // Bubble collapse on C: A and B compact towards the output while stalled
    c_out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_data = 32'hA; tick();
    c_in_valid = 1'b0; tick(); tick();
    c_in_valid = 1'b1; c_in_data = 32'hB; tick();
    c_in_valid = 1'b0; tick(); tick();
    chk("bubble_ov", {31'd0, c_out_valid}, 32'd1);
    chk("bubble_od_A", c_out_data, 32'hA);
    chk("bubble_cnt", {29'd0, c_count}, 32'd2);
    $display("bubble: out_data=%0h count=%0d", c_out_data, c_count);
    c_out_ready = 1'b1;
    tick();
    chk("bubble_B_next_ov", {31'd0, c_out_valid}, 32'd1);
    chk("bubble_B_next_od", c_out_data, 32'hB);
    chk("bubble_B_next_cnt", {29'd0, c_count}, 32'd1);
    tick();
    chk("bubble_drained_ov", {31'd0, c_out_valid}, 32'd0);
    $display("bubble drain: out_valid=%0b count=%0d", c_out_valid, c_count);

    // Flush on A with three entries held and a simultaneous push of 0x55
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h21 + 32'(i);
      tick();
    end
    chk("flush_pre_cnt", {29'd0, a_count}, 32'd3);
    chk("flush_pre_od", a_out_data, 32'h21);
    a_flush = 1'b1; a_in_data = 32'h55;
    tick();
    chk("flush_cnt", {29'd0, a_count}, 32'd0);
    chk("flush_ov", {31'd0, a_out_valid}, 32'd0);
    chk("flush_data_held", a_out_data, 32'h21);
    $display("flush: count=%0d out_valid=%0b out_data=%0h", a_count, a_out_valid, a_out_data);
    a_flush = 1'b0; a_in_data = 32'h66; a_out_ready = 1'b1;
    tick();
    chk("postflush_cnt1", {29'd0, a_count}, 32'd1);
    a_in_valid = 1'b0;
    tick();
    chk("postflush_ov_early", {31'd0, a_out_valid}, 32'd0);
    tick();
    chk("postflush_ov", {31'd0, a_out_valid}, 32'd1);
    chk("postflush_od", a_out_data, 32'h66);
    $display("post-flush push: out_data=%0h count=%0d", a_out_data, a_count);
    tick();
    chk("postflush_cnt0", {29'd0, a_count}, 32'd0);

    // SKID=0 on D: in_ready follows out_ready combinationally once full
    d_out_ready = 1'b0;
    chk("d_empty_in_ready", {31'd0, d_in_ready}, 32'd1);
    d_in_valid = 1'b1; d_in_data = 32'h1; tick();
    d_in_data = 32'h2; tick();
    chk("d_full_cnt", {30'd0, d_count}, 32'd2);
    chk("d_full_in_ready0", {31'd0, d_in_ready}, 32'd0);
    d_out_ready = 1'b1; #1;
    chk("d_track_in_ready1", {31'd0, d_in_ready}, 32'd1);
    d_flush = 1'b1; #1;
    chk("d_flush_in_ready0", {31'd0, d_in_ready}, 32'd0);
    d_flush = 1'b0; d_out_ready = 1'b0; #1;
    chk("d_track_in_ready0", {31'd0, d_in_ready}, 32'd0);
    d_in_valid = 1'b0;
    $display("skid0: count=%0d in_ready=%0b", d_count, d_in_ready);

    // Asynchronous reset mid-cycle on A holding two entries
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h31; tick();
    a_in_data = 32'h32; tick();
    a_in_valid = 1'b0;
    chk("arst_pre_cnt", {29'd0, a_count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", {31'd0, a_out_valid}, 32'd0);
    chk("arst_cnt", {29'd0, a_count}, 32'd0);
    chk("arst_od", a_out_data, 32'hDEAD_BEEF);
    chk("arst_d_cnt", {30'd0, d_count}, 32'd0);
    $display("async reset: out_valid=%0b count=%0d out_data=%0h", a_out_valid, a_count, a_out_data);
    #1 rst_n = 1'b1;
    tick();
    chk("arst_after_cnt", {29'd0, a_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the single-cycle datapath holding registers (IR/AR/BR-style) in the MIPS32 core.
- Implements a DEPTH-stage pipeline register chain with valid/ready handshake, bubble collapse, synchronous flush and an optional skid buffer.
- Provides an occupancy counter.
- Intended for IF/ID, ID/EX, EX/MEM and MEM/WB boundaries of the pipelined core, where stalls and branch flushes are required.

Parameters:
- WIDTH, 32: payload width in bits (1..128).
- DEPTH, 1: number of register stages in the chain (1..8).
- SKID, 1: 1 inserts a skid entry so in_ready is a register output; 0 makes in_ready combinational from out_ready.
- RESET_VAL, 0: value loaded into every data register on reset.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: block can accept the payload this cycle.
- in_data, input, WIDTH: upstream payload.
- out_valid, output, 1: stage DEPTH-1 holds valid payload.
- out_ready, input, 1: downstream accepts the payload this cycle.
- out_data, output, WIDTH: payload of stage DEPTH-1.
- flush, input, 1: synchronous kill of all in-flight payloads.
- count, output, $clog2(DEPTH+SKID+1): number of valid entries held, including the skid entry.

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low, applied on rst_n falling and held while rst_n=0.
- Reset state:
  - all stage and skid valid bits 0; all data registers RESET_VAL;
  - out_valid=0; out_data=RESET_VAL; count=0;
  - in_ready=1 when SKID=1; in_ready=out_ready-derived when SKID=0.
- Stage model:
  - Stages S0..S(DEPTH-1) each hold v[k] and d[k].
  - out_valid=v[DEPTH-1]; out_data=d[DEPTH-1], driven directly by a register.
  - Stage k can accept when c[k] = !v[k] | c[k+1]; c[DEPTH] = out_ready.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
- Transfers:
  - Output transfer: out_valid & out_ready at a rising edge.
  - Input transfer: in_valid & in_ready at a rising edge.
  - Data in a stage is never modified unless that stage loads.
- Latency: with an empty chain and no stall, an input transfer at edge N gives out_valid=1 after edge N+DEPTH-1 (visible at cycle N+DEPTH-1). Throughput is 1 per cycle while out_ready=1.
- SKID=0: in_ready = c[0] & !flush (combinational).
- SKID=1:
  - in_ready = !skid_v (registered).
  - If an input transfer occurs while !c[0], the payload goes to the skid entry.
  - The skid entry drains into S0 when c[0]=1 and has priority over in_data.
  - Once drained, skid_v clears at that edge.
  - Input transfer and skid drain in the same cycle: the skid goes to S0 and the new input goes to skid.
- Flush:
  - At an edge with flush=1, all v[k] and skid_v clear.
  - Any input transfer in that cycle is discarded.
  - An output transfer in that cycle counts as completed.
  - Data registers hold their values.
  - flush overrides every other event. The next edge accepts normally.
- count:
  - Registered; equals the sum of all valid bits after each edge.
  - Increments on input-only, decrements on output-only, unchanged on both.
  - Cleared to 0 by flush.
  - Never exceeds DEPTH+SKID; never underflows.
- Full: count=DEPTH+SKID and out_ready=0 gives in_ready=0 (SKID=1 registered), and no state changes.
- Empty: count=0 gives out_valid=0. out_ready is ignored.
- Reset asserted mid-stream: all payloads are lost immediately; no output transfer is reported after rst_n falls.
- in_data and out_ready are don't-care when their valids are low. No X is propagated into valid bits.

Test Plan:
- Reset with DEPTH=3, SKID=1, RESET_VAL=32'hDEAD_BEEF -> out_valid=0, out_data=32'hDEADBEEF, count=0, in_ready=1.
- Streaming with DEPTH=3, out_ready=1, inputs 1,2,3,4 on consecutive cycles -> out_data 1..4 on 4 consecutive cycles, first appearing 2 cycles after the first accept; count peaks at 3.
- Backpressure with DEPTH=2, SKID=1, out_ready=0, push 10,11,12 -> count=3, in_ready=0; a 4th push is not accepted. Then out_ready=1 -> 10,11,12 emerge in order, none lost or duplicated.
- Bubble collapse with DEPTH=4: push A, idle 2 cycles, push B, with out_ready=0 throughout -> A at S3, B at S2, count=2.
- Flush with 3 entries held and a simultaneous in_valid=1 (data 0x55) -> after the edge count=0, out_valid=0, 0x55 never appears at the output. The next push works normally.
- Async reset: drop rst_n mid-cycle while count=2 -> out_valid=0 and count=0 before the next clock edge. With SKID=0, in_ready must track out_ready combinationally.
